// File: rtl/data_bus_responder.sv
// CPU data-port responder: byte-strobed word SRAM plus a 16-byte MMIO page
// (cycle counter, console FIFO, halt). Optional counter: DBR_CYCLE_COUNTER_EN.
module data_bus_responder #(
  parameter int          DEPTH      = 4096,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
  output logic        halt,
  output logic [30:0] exit_code
);
  localparam int          NUM_LANES  = 4;
  localparam int          AW         = $clog2(DEPTH);
  localparam int          PW         = $clog2(FIFO_DEPTH);
  localparam logic [32:0] SRAM_LIMIT = 33'(DEPTH) << 2;

  logic                       sram_hit, mmio_hit;
  logic [1:0]                 reg_sel;
  logic [AW-1:0]              widx;
  logic [NUM_LANES-1:0][7:0]  sram_rdata;
  logic                       unused_addr;

  assign sram_hit    = {1'b0, data_addr} < SRAM_LIMIT;
  assign mmio_hit    = !sram_hit && (data_addr[31:4] == MMIO_BASE[31:4]);
  assign reg_sel     = data_addr[3:2];
  assign widx        = data_addr[AW+1:2];
  assign unused_addr = ^data_addr[1:0];

  // One byte-wide array per lane so each strobe is an independent write port.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    always_ff @(posedge clk)
      if (sram_hit && data_write[i]) lane_mem[widx] <= data_in[8*i +: 8];
    assign sram_rdata[i] = lane_mem[widx];
  end

  logic rd_console, push_req, halt_wr;
  assign rd_console = data_read && mmio_hit && (reg_sel == 2'd2);
  assign push_req   = data_write[0] && mmio_hit && (reg_sel == 2'd2);
  assign halt_wr    = (|data_write) && mmio_hit && (reg_sel == 2'd3);

  logic [31:0] cycle_lo, cycle_hi;
`ifdef DBR_CYCLE_COUNTER_EN
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_shadow;
  logic        rd_lo;
  assign rd_lo = data_read && mmio_hit && (reg_sel == 2'd0);

  // Reading LO snapshots HI so a LO-then-HI pair is coherent across a carry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt    <= '0;
      cycle_shadow <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (rd_lo) cycle_shadow <= cycle_cnt[63:32];
    end
  end
  assign cycle_lo = cycle_cnt[31:0];
  assign cycle_hi = cycle_shadow;
`else
  assign cycle_lo = '0;
  assign cycle_hi = '0;
`endif

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, count;
  logic        full, empty, pop, push_ok, overflow;
  logic [4:0]  count5;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign pop     = console_valid && console_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push_req && (!full || pop);
  assign count5  = 5'(count);

  always_ff @(posedge clk)
    if (push_ok) fifo_mem[wr_ptr[PW-1:0]] <= data_in[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (rd_console)      overflow <= 1'b0;
    end
  end

  assign console_valid = !empty;
  assign console_data  = empty ? 8'h00 : fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt      <= 1'b0;
      exit_code <= '0;
    end else if (halt_wr) begin
      halt      <= 1'b1;
      exit_code <= data_in[31:1];
    end
  end

  always_comb begin
    data_out = '0;
    if (data_read) begin
      if (sram_hit) data_out = sram_rdata;
      else if (mmio_hit) begin
        case (reg_sel)
          2'd0:    data_out = cycle_lo;
          2'd1:    data_out = cycle_hi;
          2'd2:    data_out = {overflow, 26'b0, count5};
          default: data_out = {exit_code, halt};
        endcase
      end
    end
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// Directed table-driven bench for data_bus_responder, plus hand sequences for
// the cycle counter and asynchronous reset.
module tb_data_bus_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        data_read;
  logic [3:0]  data_write;
  logic [31:0] data_addr, data_in, data_out;
  logic        console_valid, console_ready, halt;
  logic [7:0]  console_data;
  logic [30:0] exit_code;

  int tests = 0;
  int fails = 0;

  data_bus_responder dut (
    .clk(clk), .rst(rst), .data_read(data_read), .data_write(data_write),
    .data_addr(data_addr), .data_in(data_in), .data_out(data_out),
    .console_valid(console_valid), .console_data(console_data),
    .console_ready(console_ready), .halt(halt), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

`ifdef DBR_CYCLE_COUNTER_EN
  logic [63:0] ref_cyc;
  always @(posedge clk or negedge rst)
    if (!rst) ref_cyc <= '0;
    else      ref_cyc <= ref_cyc + 64'd1;
`endif

  typedef struct {
    string       name;
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] din;
    logic        rdy;
    logic [31:0] dout;
    logic        vld;
    logic [7:0]  cdata;
    logic        hlt;
    logic [30:0] code;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic rd, input logic [3:0] wr,
                     input logic [31:0] addr, input logic [31:0] din, input logic rdy,
                     input logic [31:0] dout, input logic vld, input logic [7:0] cdata,
                     input logic hlt, input logic [30:0] code);
    vec_t v;
    v.name = nm; v.rd = rd; v.wr = wr; v.addr = addr; v.din = din; v.rdy = rdy;
    v.dout = dout; v.vld = vld; v.cdata = cdata; v.hlt = hlt; v.code = code;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                       input logic [31:0] din, input logic rdy);
    data_read = rd; data_write = wr; data_addr = addr; data_in = din; console_ready = rdy;
  endtask

  localparam logic [31:0] CON = 32'hFFFF_0008;
  localparam logic [31:0] HLT = 32'hFFFF_000C;

  initial begin
    rst = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

    add("sram_wr_full",   0, 4'hF, 32'h100, 32'hAABB_CCDD, 0, 0, 0, 0, 0, 0);
    add("sram_wr_lane1",  0, 4'h2, 32'h100, 32'h0000_1100, 0, 0, 0, 0, 0, 0);
    add("sram_rd_merge",  1, 4'h0, 32'h100, 32'h0,         0, 32'hAABB_11DD, 0, 0, 0, 0);
    add("idle_rd0",       0, 4'h0, 32'h100, 32'h0,         0, 0, 0, 0, 0, 0);
    add("unmapped_rd",    1, 4'h0, 32'h8000_0000, 32'h0,   0, 0, 0, 0, 0, 0);
    add("unmapped_wr",    1, 4'hF, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    add("unmapped_rerd",  1, 4'h0, 32'h8000_0000, 32'h0,   0, 0, 0, 0, 0, 0);
    add("rdwr_old_data",  1, 4'hF, 32'h100, 32'hDEAD_BEEF, 0, 32'hAABB_11DD, 0, 0, 0, 0);
    add("rdwr_new_data",  1, 4'h0, 32'h100, 32'h0,         0, 32'hDEAD_BEEF, 0, 0, 0, 0);
`ifndef DBR_CYCLE_COUNTER_EN
    add("cycle_lo_off",   1, 4'h0, 32'hFFFF_0000, 32'h0,   0, 0, 0, 0, 0, 0);
    add("cycle_hi_off",   1, 4'h0, 32'hFFFF_0004, 32'h0,   0, 0, 0, 0, 0, 0);
`endif
    add("con_stat_empty", 1, 4'h0, CON, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 9; k++)
      add($sformatf("push_%0d", k), 0, 4'h1, CON, 32'h41 + k, 0, 0,
          k > 0, (k > 0) ? 8'h41 : 8'h00, 0, 0);
    add("con_stat_ovf",   1, 4'h0, CON, 32'h0, 0, 32'h8000_0008, 1, 8'h41, 0, 0);
    add("con_stat_clr",   1, 4'h0, CON, 32'h0, 0, 32'h0000_0008, 1, 8'h41, 0, 0);
    for (int k = 0; k < 8; k++)
      add($sformatf("drain_%0d", k), 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 8'(8'h41 + k), 0, 0);
    add("drained_empty",  0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++)
      add($sformatf("refill_%0d", k), 0, 4'h1, CON, 32'h61 + k, 0, 0,
          k > 0, (k > 0) ? 8'h61 : 8'h00, 0, 0);
    add("full_push_pop",  0, 4'h1, CON, 32'h5A, 1, 0, 1, 8'h61, 0, 0);
    add("full_pop_stat",  1, 4'h0, CON, 32'h0, 0, 32'h0000_0008, 1, 8'h62, 0, 0);
    for (int k = 0; k < 7; k++)
      add($sformatf("drain2_%0d", k), 0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 8'(8'h62 + k), 0, 0);
    add("drain2_last",    0, 4'h0, 32'h0, 32'h0, 1, 0, 1, 8'h5A, 0, 0);
    add("drain2_empty",   1, 4'h0, CON, 32'h0, 0, 0, 0, 0, 0, 0);
    add("halt_wr",        0, 4'h1, HLT, 32'h7, 0, 0, 0, 0, 0, 0);
    add("halt_rd",        1, 4'h0, HLT, 32'h0, 0, 32'h7, 0, 0, 1, 31'd3);
    add("halt_rewr",      0, 4'h8, HLT, 32'hA, 0, 0, 0, 0, 1, 31'd3);
    add("halt_rerd",      1, 4'h0, HLT, 32'h0, 0, 32'hB, 0, 0, 1, 31'd5);

    // Reset state, still in reset.
    #12;
    chk("rst_dout",  data_out, 32'h0);
    chk("rst_valid", 32'(console_valid), 32'h0);
    chk("rst_cdata", 32'(console_data), 32'h0);
    chk("rst_halt",  32'(halt), 32'h0);
    chk("rst_code",  32'(exit_code), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, vecs[i].rdy);
      #1;
      chk({vecs[i].name, "/dout"},  data_out, vecs[i].dout);
      chk({vecs[i].name, "/valid"}, 32'(console_valid), 32'(vecs[i].vld));
      chk({vecs[i].name, "/cdata"}, 32'(console_data), 32'(vecs[i].cdata));
      chk({vecs[i].name, "/halt"},  32'(halt), 32'(vecs[i].hlt));
      chk({vecs[i].name, "/code"},  32'(exit_code), 32'(vecs[i].code));
    end
    @(negedge clk);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

`ifdef DBR_CYCLE_COUNTER_EN
    repeat (100) @(negedge clk);
    drive(1'b1, 4'h0, 32'hFFFF_0000, 32'h0, 1'b0);
    #1 chk("cycle_lo", data_out, ref_cyc[31:0]);
    @(negedge clk);
    drive(1'b1, 4'h0, 32'hFFFF_0004, 32'h0, 1'b0);
    #1 chk("cycle_hi", data_out, 32'h0);
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0001_FFFF_FFFF;
    drive(1'b1, 4'h0, 32'hFFFF_0000, 32'h0, 1'b0);
    #1 chk("cycle_lo_forced", data_out, 32'hFFFF_FFFF);
    @(posedge clk);
    #1 release dut.cycle_cnt;
    @(negedge clk);
    drive(1'b1, 4'h0, 32'hFFFF_0004, 32'h0, 1'b0);
    #1 chk("cycle_hi_shadow", data_out, 32'h1);
    @(negedge clk);
    drive(1'b1, 4'h0, 32'hFFFF_0000, 32'h0, 1'b0);
    #1 chk("cycle_lo_wrapped", data_out, 32'h0);
`endif

    // Asynchronous reset mid-cycle with a byte in the FIFO and halt set.
    @(negedge clk);
    drive(1'b0, 4'h1, CON, 32'h77, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    #1;
    chk("pre_rst_valid", 32'(console_valid), 32'h1);
    chk("pre_rst_cdata", 32'(console_data), 32'h77);
    chk("pre_rst_halt",  32'(halt), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("async_halt",  32'(halt), 32'h0);
    chk("async_code",  32'(exit_code), 32'h0);
    chk("async_valid", 32'(console_valid), 32'h0);
    chk("async_cdata", 32'(console_data), 32'h0);
    data_read = 1'b1; data_addr = CON;
    #1 chk("async_stat", data_out, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    data_addr = HLT;
    @(negedge clk);
    #1 chk("post_rst_halt_rd", data_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_bus_responder.md
# data_bus_responder

Responder end of the CPU data-memory port: it accepts the core's `data_read`/`data_write`/`data_addr`/`data_in` requests and returns `data_out` in the same cycle. It holds a word-organised data SRAM with byte-lane write strobes and a small MMIO page. The MMIO page provides a 64-bit cycle counter, a console byte FIFO drained by an external valid/ready sink, and a halt register used by the simulation harness. It sits between the CPU and the testbench/top level, replacing the bare SRAM on the data side.

## Interface
- `DEPTH`, 4096, data SRAM depth in 32-bit words (power of two).
- `FIFO_DEPTH`, 8, console FIFO entries (power of two, ≥2).
- `MMIO_BASE`, 32'hFFFF_0000, base of the 16-byte MMIO page.
- `clk  input  1  clock, rising edge.`
- `rst  input  1  asynchronous, active-low reset.`
- `data_read  input  1  read enable from CPU.`
- `data_write  input  4  byte-lane write strobes; lane i = data_in[8i+7:8i].`
- `data_addr  input  32  byte address; bits [1:0] ignored.`
- `data_in  input  32  write data from CPU.`
- `data_out  output  32  read data to CPU, combinational.`
- `console_valid  output  1  FIFO non-empty.`
- `console_data  output  8  FIFO head byte.`
- `console_ready  input  1  sink accepts head byte.`
- `halt  output  1  sticky halt flag.`
- `exit_code  output  31  value written with halt.`

## Operation
- Decode: SRAM hit when `data_addr < DEPTH*4`. MMIO hit when `data_addr[31:4] == MMIO_BASE[31:4]`. All other addresses are unmapped.
- SRAM read: `data_out = mem[data_addr[..:2]]` whenever `data_read`=1. Writes update the lanes selected by `data_write` at the rising edge. Contents are not reset.
- MMIO map (offset):
  - 0x0 CYCLE_LO (RO): reading it latches the current counter[63:32] into a shadow register at the edge.
  - 0x4 CYCLE_HI (RO): returns the shadow.
  - 0x8 CONSOLE: a write with `data_write[0]`=1 pushes `data_in[7:0]`. A read returns {overflow[31], 26'b0, count[4:0]}; the read clears overflow at the edge.
  - 0xC HALT: a write with any strobe set sets `halt`=1 and `exit_code`=`data_in[31:1]`. A read returns {exit_code, halt}.
- Unmapped access: reads return 0, writes are ignored. No error signalling.
- `data_out` = 0 when `data_read`=0.
- `data_read` and `data_write` both asserted: the read returns pre-write data and the write takes effect at the edge.
- FIFO: pop occurs when `console_valid && console_ready`. A push to a full FIFO is dropped and sets overflow, unless a pop happens in the same cycle, in which case the push is accepted. A push to an empty FIFO is visible on `console_valid` the next cycle.
- `halt` is sticky until reset. Later HALT writes overwrite `exit_code`. SRAM/FIFO traffic continues after halt.

## Timing
- Read latency 0 cycles (combinational). Write/push/pop/register updates occur at the rising `clk` edge.
- Counter increments every cycle from 0 after reset release.
- Reset (async, `rst`=0): counter=0, shadow=0, FIFO empty (`console_valid`=0, `console_data`=0), overflow=0, `halt`=0, `exit_code`=0, `data_out` follows its combinational rule. Reset mid-drain discards FIFO contents immediately.
- Counter wraps from 2^64-1 to 0.
- FIFO pointers are log2(FIFO_DEPTH) bits wide plus one wrap bit. Count ranges 0..FIFO_DEPTH.

## Configuration
- `DBR_CYCLE_COUNTER_EN` defined: 64-bit counter and shadow are built as described.
- Not defined: counter and shadow are absent; CYCLE_LO/CYCLE_HI read 0. All other behaviour is unchanged.

## Test plan
- SRAM byte strobes: write 0xAABBCCDD to 0x100 with strobe 4'b1111, then 0x11 with strobe 4'b0010 → read 0x100 returns 0xAABB11DD.
- Unmapped/idle: read 0x8000_0000 → 0. Write there, then re-read → 0. `data_read`=0 at 0x100 → `data_out`=0.
- Console backpressure: `console_ready`=0, push 9 bytes 0x41..0x49 (FIFO_DEPTH=8) → status reads 0x8000_0008. A second status read returns 0x0000_0008. Raising ready drains 0x41..0x48 in order, one per cycle.
- Full + simultaneous pop: with FIFO full and ready=1, push 0x5A in the same cycle → no overflow, count stays 8, 0x5A is drained last.
- Cycle counter (macro on): after 100 cycles, read CYCLE_LO ≈ 100 and CYCLE_HI = 0. Force the counter to 0x0000_0001_FFFF_FFFF, read LO then HI → HI is 1 even though LO has wrapped. With the macro off, both read 0.
- Halt/reset: write 0x0000_0007 to 0xFFFF_000C → `halt`=1, `exit_code`=3. Assert `rst`=0 mid-cycle → `halt`, `exit_code`, `console_valid` drop to 0 without waiting for an edge.
